// File: rtl/id_operand_fetch_pkg.sv
// Shared constants for the decode-stage operand fetch slice.
// Scoreboard indexing: 1..31 GPR, 32 HI, 33 LO; entry 0 unused.
package id_operand_fetch_pkg;

  localparam int NUM_GPR = 32;
  localparam int SB_ENTRIES = 34;
  localparam logic [5:0] SB_HI = 6'd32;
  localparam logic [5:0] SB_LO = 6'd33;
  localparam logic [4:0] ZERO_REG = 5'd0;

  function automatic logic [5:0] gpr_idx(input logic [4:0] a);
    return {1'b0, a};
  endfunction

endpackage

// File: rtl/id_operand_fetch_pend_counter.sv
// One scoreboard entry: count of in-flight writes to a register.
// Ports: clk, clear (sync), inc, dec, count, is_max.
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              is_max
);

  logic dec_ok;

  // A retire with nothing pending writes data but leaves count at 0.
  assign dec_ok = dec & (count != '0);
  assign is_max = &count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc & ~dec_ok & ~is_max) begin
      count <= count + PEND_W'(1);
    end else if (dec_ok & ~inc) begin
      count <= count - PEND_W'(1);
    end
  end

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage GPR/HI/LO file with write-first bypass and a pending-write
// scoreboard that stalls ID on RAW hazards and counter saturation.
// Ports: clk, rst (sync high); WB writes wena_*/waddr/wdata_*;
// ID reads raddr_rs/rt, use_*; issue_* dests; rs/rt/hi/lo_data, stall.
module id_operand_fetch
  import id_operand_fetch_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wena_rf,
  input  logic [4:0]  waddr_regfiles,
  input  logic [31:0] wdata_regfiles,
  input  logic        wena_hi,
  input  logic [31:0] wdata_hi,
  input  logic        wena_lo,
  input  logic [31:0] wdata_lo,
  input  logic [4:0]  raddr_rs,
  input  logic [4:0]  raddr_rt,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic        use_hi,
  input  logic        use_lo,
  input  logic        issue_valid,
  input  logic        issue_w_rf,
  input  logic [4:0]  issue_waddr,
  input  logic        issue_w_hi,
  input  logic        issue_w_lo,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic        stall
);

  logic [31:0] gpr [NUM_GPR];
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic wr_rf;
  logic wr_hi;
  logic wr_lo;

  assign wr_rf = ~rst & wena_rf & (waddr_regfiles != ZERO_REG);
  assign wr_hi = ~rst & wena_hi;
  assign wr_lo = ~rst & wena_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wr_rf) gpr[waddr_regfiles] <= wdata_regfiles;
      if (wr_hi) hi_q <= wdata_hi;
      if (wr_lo) lo_q <= wdata_lo;
    end
  end

  always_comb begin
    rs_data = gpr[raddr_rs];
    if (raddr_rs == ZERO_REG) rs_data = '0;
    else if (wr_rf && waddr_regfiles == raddr_rs) rs_data = wdata_regfiles;
    rt_data = gpr[raddr_rt];
    if (raddr_rt == ZERO_REG) rt_data = '0;
    else if (wr_rf && waddr_regfiles == raddr_rt) rt_data = wdata_regfiles;
    hi_data = wr_hi ? wdata_hi : hi_q;
    lo_data = wr_lo ? wdata_lo : lo_q;
  end

  logic [PEND_W-1:0]     cnt [SB_ENTRIES];
  logic                  at_max [SB_ENTRIES];
  logic [SB_ENTRIES-1:0] inc;
  logic [SB_ENTRIES-1:0] dec;
  logic                  accept;
  logic                  dst_rf;

  assign cnt[0] = '0;
  assign at_max[0] = 1'b0;

  for (genvar e = 1; e < SB_ENTRIES; e++) begin : g_sb
    pend_counter #(.PEND_W(PEND_W)) u_pc (
      .clk    (clk),
      .clear  (rst),
      .inc    (inc[e]),
      .dec    (dec[e]),
      .count  (cnt[e]),
      .is_max (at_max[e])
    );
  end

  always_comb begin
    dec = '0;
    if (wr_rf) dec[gpr_idx(waddr_regfiles)] = 1'b1;
    if (wr_hi) dec[SB_HI] = 1'b1;
    if (wr_lo) dec[SB_LO] = 1'b1;
  end

  assign dst_rf = issue_w_rf & (issue_waddr != ZERO_REG);

  logic blk_rs;
  logic blk_rt;
  logic blk_hi;
  logic blk_lo;
  logic full;

  // A retiring write this cycle covers one pending count.
  always_comb begin
    blk_rs = use_rs & (raddr_rs != ZERO_REG) &
             (cnt[gpr_idx(raddr_rs)] > PEND_W'(dec[gpr_idx(raddr_rs)]));
    blk_rt = use_rt & (raddr_rt != ZERO_REG) &
             (cnt[gpr_idx(raddr_rt)] > PEND_W'(dec[gpr_idx(raddr_rt)]));
    blk_hi = use_hi & (cnt[SB_HI] > PEND_W'(dec[SB_HI]));
    blk_lo = use_lo & (cnt[SB_LO] > PEND_W'(dec[SB_LO]));
    full = (dst_rf & at_max[gpr_idx(issue_waddr)] &
            ~dec[gpr_idx(issue_waddr)])
         | (issue_w_hi & at_max[SB_HI] & ~dec[SB_HI])
         | (issue_w_lo & at_max[SB_LO] & ~dec[SB_LO]);
  end

  assign stall = ~rst & issue_valid &
                 (blk_rs | blk_rt | blk_hi | blk_lo | full);
  assign accept = ~rst & issue_valid & ~stall;

  always_comb begin
    inc = '0;
    if (accept & dst_rf) inc[gpr_idx(issue_waddr)] = 1'b1;
    if (accept & issue_w_hi) inc[SB_HI] = 1'b1;
    if (accept & issue_w_lo) inc[SB_LO] = 1'b1;
  end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed-vector bench for id_operand_fetch.
// Drives after the rising edge, samples combinational outputs mid-cycle.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        wena_rf;
  logic [4:0]  waddr_regfiles;
  logic [31:0] wdata_regfiles;
  logic        wena_hi;
  logic [31:0] wdata_hi;
  logic        wena_lo;
  logic [31:0] wdata_lo;
  logic [4:0]  raddr_rs;
  logic [4:0]  raddr_rt;
  logic        use_rs;
  logic        use_rt;
  logic        use_hi;
  logic        use_lo;
  logic        issue_valid;
  logic        issue_w_rf;
  logic [4:0]  issue_waddr;
  logic        issue_w_hi;
  logic        issue_w_lo;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_operand_fetch #(.PEND_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wena_rf        (wena_rf),
    .waddr_regfiles (waddr_regfiles),
    .wdata_regfiles (wdata_regfiles),
    .wena_hi        (wena_hi),
    .wdata_hi       (wdata_hi),
    .wena_lo        (wena_lo),
    .wdata_lo       (wdata_lo),
    .raddr_rs       (raddr_rs),
    .raddr_rt       (raddr_rt),
    .use_rs         (use_rs),
    .use_rt         (use_rt),
    .use_hi         (use_hi),
    .use_lo         (use_lo),
    .issue_valid    (issue_valid),
    .issue_w_rf     (issue_w_rf),
    .issue_waddr    (issue_waddr),
    .issue_w_hi     (issue_w_hi),
    .issue_w_lo     (issue_w_lo),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .hi_data        (hi_data),
    .lo_data        (lo_data),
    .stall          (stall)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wena_rf = 0; waddr_regfiles = 0; wdata_regfiles = 0;
    wena_hi = 0; wdata_hi = 0; wena_lo = 0; wdata_lo = 0;
    raddr_rs = 0; raddr_rt = 0;
    use_rs = 0; use_rt = 0; use_hi = 0; use_lo = 0;
    issue_valid = 0; issue_w_rf = 0; issue_waddr = 0;
    issue_w_hi = 0; issue_w_lo = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_rf(input logic [4:0] a, input logic [31:0] d);
    wena_rf = 1; waddr_regfiles = a; wdata_regfiles = d;
  endtask

  task automatic iss_rf(input logic [4:0] a);
    issue_valid = 1; issue_w_rf = 1; issue_waddr = a;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;

    // reset state
    raddr_rs = 5; raddr_rt = 0; use_rs = 1; use_rt = 1; issue_valid = 1;
    #1;
    chk("rst_rs", rs_data, 32'h0);
    chk("rst_rt", rt_data, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_hi", hi_data, 32'h0);
    tick(); idle();

    // write-first bypass
    wb_rf(7, 32'hDEAD_BEEF); raddr_rs = 7;
    #1 chk("byp_same", rs_data, 32'hDEAD_BEEF);
    tick(); idle(); raddr_rs = 7;
    #1 chk("byp_next", rs_data, 32'hDEAD_BEEF);

    // RAW stall on $3
    idle(); iss_rf(3);
    #1 chk("raw_iss", {31'b0, stall}, 32'h0);
    tick(); idle();
    issue_valid = 1; use_rs = 1; raddr_rs = 3;
    #1 chk("raw_stall1", {31'b0, stall}, 32'h1);
    tick();
    chk("raw_stall2", {31'b0, stall}, 32'h1);
    wb_rf(3, 32'h0000_1234);
    #1 chk("raw_wb_stall", {31'b0, stall}, 32'h0);
    chk("raw_wb_rs", rs_data, 32'h0000_1234);
    tick(); idle();

    // HI/LO
    issue_valid = 1; issue_w_hi = 1; issue_w_lo = 1;
    #1 chk("mult_iss", {31'b0, stall}, 32'h0);
    tick(); idle();
    issue_valid = 1; use_hi = 1;
    #1 chk("mfhi_stall", {31'b0, stall}, 32'h1);
    tick();
    use_lo = 1;
    wena_hi = 1; wdata_hi = 32'h1; wena_lo = 1; wdata_lo = 32'h2;
    #1 chk("hilo_stall", {31'b0, stall}, 32'h0);
    chk("hilo_hi", hi_data, 32'h1);
    chk("hilo_lo", lo_data, 32'h2);
    tick(); idle();
    issue_valid = 1; use_hi = 1; use_lo = 1;
    #1 chk("hilo_clear", {31'b0, stall}, 32'h0);
    chk("hi_held", hi_data, 32'h1);
    tick(); idle();

    // saturation of $9
    for (int i = 0; i < 3; i++) begin
      iss_rf(9);
      #1 chk("sat_iss", {31'b0, stall}, 32'h0);
      tick();
    end
    iss_rf(9);
    #1 chk("sat_full", {31'b0, stall}, 32'h1);
    wb_rf(9, 32'h99);
    #1 chk("sat_retire", {31'b0, stall}, 32'h0);
    tick(); idle();
    iss_rf(9);
    #1 chk("sat_still3", {31'b0, stall}, 32'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      wb_rf(9, 32'h90 + i);
      tick();
    end
    idle(); issue_valid = 1; use_rs = 1; raddr_rs = 9;
    #1 chk("sat_drain", {31'b0, stall}, 32'h0);
    chk("sat_data", rs_data, 32'h92);
    tick(); idle();

    // $0 never tracked
    for (int i = 0; i < 4; i++) begin
      iss_rf(0);
      #1 chk("z_iss", {31'b0, stall}, 32'h0);
      tick();
    end
    idle(); issue_valid = 1; use_rs = 1; raddr_rs = 0;
    #1 chk("z_read", {31'b0, stall}, 32'h0);
    wb_rf(0, 32'h5);
    #1 chk("z_byp", rs_data, 32'h0);
    tick(); idle(); raddr_rs = 0;
    #1 chk("z_hold", rs_data, 32'h0);

    // retire with nothing pending: no underflow
    wb_rf(12, 32'hC);
    tick(); idle();
    issue_valid = 1; use_rs = 1; raddr_rs = 12;
    #1 chk("uf_stall", {31'b0, stall}, 32'h0);
    chk("uf_data", rs_data, 32'hC);
    tick(); idle();

    // source equals own destination
    iss_rf(5); use_rs = 1; raddr_rs = 5;
    #1 chk("self_iss", {31'b0, stall}, 32'h0);
    tick();
    #1 chk("self_next", {31'b0, stall}, 32'h1);
    idle(); wb_rf(5, 32'h55);
    tick(); idle();

    // reset mid-operation
    iss_rf(4);
    tick(); idle();
    rst = 1; issue_valid = 1; use_rs = 1; raddr_rs = 4;
    wb_rf(8, 32'h88);
    #1 chk("mrst_stall", {31'b0, stall}, 32'h0);
    tick(); idle(); rst = 0;
    issue_valid = 1; use_rs = 1; raddr_rs = 4; raddr_rt = 8;
    #1 chk("mrst_clr", {31'b0, stall}, 32'h0);
    chk("mrst_wbign", rt_data, 32'h0);
    raddr_rt = 7;
    #1 chk("mrst_gpr", rt_data, 32'h0);
    tick(); idle();
    wb_rf(4, 32'h44);
    tick(); idle(); raddr_rs = 4;
    #1 chk("mrst_late_wb", rs_data, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
